// File: rtl/int_seq.sv
// Interrupt/reset sequencer: injects BRK at opcode fetch for RESET, NMI and IRQ and holds
// the service context until the vector fetch completes. Optional macro: NMI_HIJACK_EN.
module int_seq (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_din,
    input  logic       i_sync,
    input  logic       i_ready,
    input  logic       i_nmi_n,
    input  logic       i_irq_n,
    input  logic       i_iflag,
    input  logic       i_vec_fetch,
    input  logic       i_vec_done,
    output logic [7:0] o_op,
    output logic       o_inject,
    output logic [1:0] o_src,
    output logic [7:0] o_vec_lo,
    output logic       o_bflag,
    output logic       o_pc_hold,
    output logic       o_write_inhibit,
    output logic       o_busy
);

    localparam logic [1:0] S_RST = 2'd0;
    localparam logic [1:0] S_RUN = 2'd1;
    localparam logic [1:0] S_SVC = 2'd2;

    localparam logic [1:0] SRC_BRK = 2'b00;
    localparam logic [1:0] SRC_IRQ = 2'b01;
    localparam logic [1:0] SRC_NMI = 2'b10;
    localparam logic [1:0] SRC_RST = 2'b11;

    logic [1:0] state_q, state_d;
    logic       nmi_s1_q, nmi_s2_q, nmi_prev_q;
    logic       irq_s1_q, irq_s2_q;
    logic       nmi_pend_q, nmi_pend_d;
    logic [1:0] src_q, src_d;
    logic [7:0] vec_q, vec_d;
    logic       bflag_q, bflag_d;
    logic       pch_q, pch_d;
    logic       wi_q, wi_d;
    logic       busy_q, busy_d;
    logic       nmi_fall, nmi_clr, irq_req, take;

    // Two-flop synchronizers; nmi_prev_q gives one more stage for the falling-edge detect
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            nmi_s1_q   <= 1'b1;
            nmi_s2_q   <= 1'b1;
            nmi_prev_q <= 1'b1;
            irq_s1_q   <= 1'b1;
            irq_s2_q   <= 1'b1;
        end else begin
            nmi_s1_q   <= i_nmi_n;
            nmi_s2_q   <= nmi_s1_q;
            nmi_prev_q <= nmi_s2_q;
            irq_s1_q   <= i_irq_n;
            irq_s2_q   <= irq_s1_q;
        end
    end

    assign nmi_fall = nmi_prev_q & ~nmi_s2_q;
    assign irq_req  = ~irq_s2_q & ~i_iflag;
    assign take     = i_sync & i_ready & ((state_q == S_RST) | (state_q == S_RUN));
    assign o_inject = i_sync & ((state_q == S_RST) |
                                ((state_q == S_RUN) & (nmi_pend_q | irq_req)));
    assign o_op     = o_inject ? 8'h00 : i_din;

`ifdef NMI_HIJACK_EN
    logic lock_q, lock_d;

    // Vector is frozen from the edge the decoder reads its low byte
    assign lock_d = (state_q == S_SVC) & (lock_q | (i_ready & i_vec_fetch));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) lock_q <= 1'b0;
        else          lock_q <= lock_d;
    end
`else
    logic unused_vec_fetch;
    assign unused_vec_fetch = i_vec_fetch;
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        vec_d   = vec_q;
        bflag_d = bflag_q;
        pch_d   = pch_q;
        wi_d    = wi_q;
        busy_d  = busy_q;
        nmi_clr = 1'b0;
        if (take) begin
            if (state_q == S_RST) begin
                state_d = S_SVC; src_d = SRC_RST; vec_d = 8'hFC;
                bflag_d = 1'b0;  pch_d = 1'b1;    wi_d = 1'b1; busy_d = 1'b1;
            end else if (nmi_pend_q) begin
                state_d = S_SVC; src_d = SRC_NMI; vec_d = 8'hFA;
                bflag_d = 1'b0;  pch_d = 1'b1;    wi_d = 1'b0; busy_d = 1'b1;
                nmi_clr = 1'b1;
            end else if (irq_req) begin
                state_d = S_SVC; src_d = SRC_IRQ; vec_d = 8'hFE;
                bflag_d = 1'b0;  pch_d = 1'b1;    wi_d = 1'b0; busy_d = 1'b1;
            end else if (i_din == 8'h00) begin
                state_d = S_SVC; src_d = SRC_BRK; vec_d = 8'hFE;
                bflag_d = 1'b1;  pch_d = 1'b0;    wi_d = 1'b0; busy_d = 1'b1;
            end
        end else if ((state_q == S_SVC) && i_ready) begin
            if (i_vec_done) begin
                state_d = S_RUN; src_d = SRC_BRK; vec_d = 8'hFE;
                bflag_d = 1'b1;  pch_d = 1'b0;    wi_d = 1'b0; busy_d = 1'b0;
            end
`ifdef NMI_HIJACK_EN
            else if (!lock_q && !i_vec_fetch && nmi_pend_q && !src_q[1]) begin
                src_d   = SRC_NMI;
                vec_d   = 8'hFA;
                nmi_clr = 1'b1;
            end
`endif
        end else if (state_q == 2'd3) begin
            state_d = S_RST;
        end
        // A new edge landing with the take-clear keeps the request pending
        nmi_pend_d = nmi_fall | (nmi_pend_q & ~nmi_clr);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_RST;
            nmi_pend_q <= 1'b0;
            src_q      <= SRC_RST;
            vec_q      <= 8'hFC;
            bflag_q    <= 1'b0;
            pch_q      <= 1'b1;
            wi_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            nmi_pend_q <= nmi_pend_d;
            src_q      <= src_d;
            vec_q      <= vec_d;
            bflag_q    <= bflag_d;
            pch_q      <= pch_d;
            wi_q       <= wi_d;
            busy_q     <= busy_d;
        end
    end

    assign o_src           = src_q;
    assign o_vec_lo        = vec_q;
    assign o_bflag         = bflag_q;
    assign o_pc_hold       = pch_q;
    assign o_write_inhibit = wi_q;
    assign o_busy          = busy_q;

endmodule

// File: tb/tb_int_seq.sv
// Self-checking bench for int_seq: directed scenarios plus randomized run against a
// behavioural model of the sequencer rules.
module tb_int_seq;

    logic       clk = 1'b0;
    logic       rst_n, sync, ready, nmi_n, irq_n, iflag, vec_fetch, vec_done;
    logic [7:0] din;
    wire  [7:0] o_op, o_vec_lo;
    wire        o_inject, o_bflag, o_pc_hold, o_write_inhibit, o_busy;
    wire  [1:0] o_src;
    wire  [13:0] lat = {o_src, o_vec_lo, o_bflag, o_pc_hold, o_write_inhibit, o_busy};
    wire  [8:0]  opi = {o_op, o_inject};

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [13:0] L_RST_IDLE = {2'b11, 8'hFC, 4'b0110};
    localparam logic [13:0] L_RST_SVC  = {2'b11, 8'hFC, 4'b0111};
    localparam logic [13:0] L_IDLE     = {2'b00, 8'hFE, 4'b1000};
    localparam logic [13:0] L_NMI      = {2'b10, 8'hFA, 4'b0101};
    localparam logic [13:0] L_IRQ      = {2'b01, 8'hFE, 4'b0101};
    localparam logic [13:0] L_BRK      = {2'b00, 8'hFE, 4'b1001};
    localparam logic [13:0] L_HIJ      = {2'b10, 8'hFA, 4'b1001};

    always #5 clk = ~clk;

    int_seq dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_din(din), .i_sync(sync), .i_ready(ready),
        .i_nmi_n(nmi_n), .i_irq_n(irq_n), .i_iflag(iflag), .i_vec_fetch(vec_fetch),
        .i_vec_done(vec_done), .o_op(o_op), .o_inject(o_inject), .o_src(o_src),
        .o_vec_lo(o_vec_lo), .o_bflag(o_bflag), .o_pc_hold(o_pc_hold),
        .o_write_inhibit(o_write_inhibit), .o_busy(o_busy)
    );

    // Behavioural model: mode 0 = reset pending, 1 = running, 2 = in service
    int         m_mode;
    bit         m_pend, m_lock;
    bit   [1:0] m_src;
    bit   [7:0] m_vec;
    bit         m_bflag, m_pch, m_wi, m_busy;
    bit         m_nq[$];
    bit         m_iq[$];

    task automatic m_set(input bit [1:0] s, input bit [7:0] v, input bit b, input bit p,
                         input bit w, input bit bz);
        m_src = s; m_vec = v; m_bflag = b; m_pch = p; m_wi = w; m_busy = bz;
    endtask

    task automatic m_reset();
        m_mode = 0; m_pend = 0; m_lock = 0;
        m_set(2'b11, 8'hFC, 1'b0, 1'b1, 1'b1, 1'b0);
        m_nq = {1'b1, 1'b1, 1'b1};
        m_iq = {1'b1, 1'b1, 1'b1};
    endtask

    // Pin queues hold the last three samples, oldest first; the synchronized level is
    // the sample taken two edges ago, so element [1], and element [0] is the one before.
    function automatic bit m_irq_req();
        return !m_iq[1] && !iflag;
    endfunction

    function automatic bit m_inject();
        return sync && (m_mode == 0 || (m_mode == 1 && (m_pend || m_irq_req())));
    endfunction

    task automatic m_edge();
        bit fall;
        bit irqr;
        fall = m_nq[0] && !m_nq[1];
        irqr = m_irq_req();
        if (ready) begin
            if (sync && m_mode != 2) begin
                if (m_mode == 0) begin
                    m_set(2'b11, 8'hFC, 0, 1, 1, 1); m_mode = 2; m_lock = 0;
                end else if (m_pend) begin
                    m_set(2'b10, 8'hFA, 0, 1, 0, 1); m_mode = 2; m_lock = 0; m_pend = 0;
                end else if (irqr) begin
                    m_set(2'b01, 8'hFE, 0, 1, 0, 1); m_mode = 2; m_lock = 0;
                end else if (din == 8'h00) begin
                    m_set(2'b00, 8'hFE, 1, 0, 0, 1); m_mode = 2; m_lock = 0;
                end
            end else if (m_mode == 2) begin
                if (vec_done) begin
                    m_set(2'b00, 8'hFE, 1, 0, 0, 0); m_mode = 1;
                end
`ifdef NMI_HIJACK_EN
                else begin
                    if (!m_lock && !vec_fetch && m_pend && (m_src == 2'b00 || m_src == 2'b01)) begin
                        m_src = 2'b10; m_vec = 8'hFA; m_pend = 0;
                    end
                    if (vec_fetch) m_lock = 1;
                end
`endif
            end
        end
        if (fall) m_pend = 1;
        m_nq.push_back(nmi_n); void'(m_nq.pop_front());
        m_iq.push_back(irq_n); void'(m_iq.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) m_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; m_reset(); sync = 0; din = 8'hA9;
        repeat (2) tick();
        n_tests++;
        if (lat !== L_RST_IDLE) begin n_fail++; $display("FAIL reset_latched: got %h want %h", lat, L_RST_IDLE); end
        n_tests++;
        if (opi !== {8'hA9, 1'b0}) begin n_fail++; $display("FAIL reset_comb_nosync: got %h want %h", opi, {8'hA9, 1'b0}); end
        sync = 1; #1;
        n_tests++;
        if (opi !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL reset_comb_sync: got %h want %h", opi, {8'h00, 1'b1}); end
        sync = 0;
    endtask

    task automatic test_reset_seq();
        rst_n = 1; sync = 1; din = 8'hA9; #1;
        n_tests++;
        if (opi !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL rstseq_inject: got %h want %h", opi, {8'h00, 1'b1}); end
        tick(); sync = 0;
        n_tests++;
        if (lat !== L_RST_SVC) begin n_fail++; $display("FAIL rstseq_latched: got %h want %h", lat, L_RST_SVC); end
        vec_done = 1; tick(); vec_done = 0;
        n_tests++;
        if (lat !== L_IDLE) begin n_fail++; $display("FAIL rstseq_done: got %h want %h", lat, L_IDLE); end
    endtask

    task automatic test_passthru();
        sync = 1; din = 8'hA9; #1;
        n_tests++;
        if (opi !== {8'hA9, 1'b0}) begin n_fail++; $display("FAIL pass_op: got %h want %h", opi, {8'hA9, 1'b0}); end
        tick(); sync = 0;
        n_tests++;
        if (lat !== L_IDLE) begin n_fail++; $display("FAIL pass_state: got %h want %h", lat, L_IDLE); end
    endtask

    task automatic nmi_pulse();
        nmi_n = 0; tick(); tick(); nmi_n = 1; tick(); tick();
    endtask

    task automatic test_nmi();
        sync = 1; din = 8'hA9; nmi_n = 0;
        tick(); tick(); nmi_n = 1;
        n_tests++;
        if (opi !== {8'hA9, 1'b0}) begin n_fail++; $display("FAIL nmi_early: got %h want %h", opi, {8'hA9, 1'b0}); end
        tick();
        n_tests++;
        if (opi !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL nmi_latency: got %h want %h", opi, {8'h00, 1'b1}); end
        tick(); sync = 0;
        n_tests++;
        if (lat !== L_NMI) begin n_fail++; $display("FAIL nmi_latched: got %h want %h", lat, L_NMI); end
        vec_done = 1; tick(); vec_done = 0;
        sync = 1; din = 8'hEA; #1;
        n_tests++;
        if (opi !== {8'hEA, 1'b0}) begin n_fail++; $display("FAIL nmi_cleared: got %h want %h", opi, {8'hEA, 1'b0}); end
        tick(); sync = 0;
    endtask

    task automatic test_irq();
        irq_n = 0; iflag = 1; tick(); tick();
        sync = 1; din = 8'hA9; #1;
        n_tests++;
        if (opi !== {8'hA9, 1'b0}) begin n_fail++; $display("FAIL irq_masked: got %h want %h", opi, {8'hA9, 1'b0}); end
        iflag = 0; #1;
        n_tests++;
        if (opi !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL irq_inject: got %h want %h", opi, {8'h00, 1'b1}); end
        tick(); sync = 0;
        n_tests++;
        if (lat !== L_IRQ) begin n_fail++; $display("FAIL irq_latched: got %h want %h", lat, L_IRQ); end
        vec_done = 1; tick(); vec_done = 0;
        nmi_pulse();
        sync = 1; tick(); sync = 0;
        n_tests++;
        if (lat !== L_NMI) begin n_fail++; $display("FAIL nmi_over_irq: got %h want %h", lat, L_NMI); end
        vec_done = 1; tick(); vec_done = 0;
        irq_n = 1; iflag = 1; tick(); tick();
    endtask

    task automatic test_brk();
        sync = 1; din = 8'h00; #1;
        n_tests++;
        if (opi !== {8'h00, 1'b0}) begin n_fail++; $display("FAIL brk_noinject: got %h want %h", opi, {8'h00, 1'b0}); end
        tick(); sync = 0;
        n_tests++;
        if (lat !== L_BRK) begin n_fail++; $display("FAIL brk_latched: got %h want %h", lat, L_BRK); end
        nmi_n = 0; tick(); tick(); nmi_n = 1; tick(); tick();
`ifdef NMI_HIJACK_EN
        n_tests++;
        if (lat !== L_HIJ) begin n_fail++; $display("FAIL brk_hijack: got %h want %h", lat, L_HIJ); end
`else
        n_tests++;
        if (lat !== L_BRK) begin n_fail++; $display("FAIL brk_nohijack: got %h want %h", lat, L_BRK); end
`endif
        vec_fetch = 1; tick(); vec_fetch = 0;
        vec_done = 1; tick(); vec_done = 0;
        n_tests++;
        if (lat !== L_IDLE) begin n_fail++; $display("FAIL brk_done: got %h want %h", lat, L_IDLE); end
        sync = 1; din = 8'hA9; #1;
`ifdef NMI_HIJACK_EN
        n_tests++;
        if (opi !== {8'hA9, 1'b0}) begin n_fail++; $display("FAIL brk_after_hijack: got %h want %h", opi, {8'hA9, 1'b0}); end
        tick(); sync = 0;
`else
        n_tests++;
        if (opi !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL brk_nmi_deferred: got %h want %h", opi, {8'h00, 1'b1}); end
        tick(); sync = 0;
        n_tests++;
        if (lat !== L_NMI) begin n_fail++; $display("FAIL brk_nmi_taken: got %h want %h", lat, L_NMI); end
        vec_done = 1; tick(); vec_done = 0;
`endif
    endtask

    task automatic test_ready();
        nmi_pulse();
        ready = 0; sync = 1; din = 8'hA9; #1;
        n_tests++;
        if (opi !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL rdy_inject: got %h want %h", opi, {8'h00, 1'b1}); end
        tick(); tick();
        n_tests++;
        if ({o_inject, lat} !== {1'b1, L_IDLE}) begin n_fail++; $display("FAIL rdy_hold: got %h want %h", {o_inject, lat}, {1'b1, L_IDLE}); end
        ready = 1; tick(); sync = 0;
        n_tests++;
        if (lat !== L_NMI) begin n_fail++; $display("FAIL rdy_take: got %h want %h", lat, L_NMI); end
        ready = 0; vec_done = 1; tick();
        n_tests++;
        if (lat !== L_NMI) begin n_fail++; $display("FAIL rdy_done_held: got %h want %h", lat, L_NMI); end
        ready = 1; tick(); vec_done = 0;
        n_tests++;
        if (lat !== L_IDLE) begin n_fail++; $display("FAIL rdy_done: got %h want %h", lat, L_IDLE); end
    endtask

    task automatic test_reset_mid();
        sync = 1; din = 8'h00; tick(); sync = 0;
        #2 rst_n = 0; m_reset(); #1;
        n_tests++;
        if (lat !== L_RST_IDLE) begin n_fail++; $display("FAIL midrst_async: got %h want %h", lat, L_RST_IDLE); end
        tick(); rst_n = 1;
        sync = 1; din = 8'hA9; #1;
        n_tests++;
        if (opi !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL midrst_inject: got %h want %h", opi, {8'h00, 1'b1}); end
        tick(); sync = 0;
        vec_done = 1; tick(); vec_done = 0;
    endtask

    task automatic test_random();
        logic [22:0] exp_v;
        logic [22:0] act_v;
        bit          inj;
        rst_n = 0; m_reset(); tick(); rst_n = 1;
        for (int i = 0; i < 3000; i++) begin
            sync      = ($urandom_range(0, 2) == 0);
            din       = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            ready     = ($urandom_range(0, 7) != 0);
            vec_done  = ($urandom_range(0, 7) == 0);
            vec_fetch = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 15) == 0) nmi_n = ~nmi_n;
            if ($urandom_range(0, 19) == 0) irq_n = ~irq_n;
            if ($urandom_range(0, 9) == 0)  iflag = ~iflag;
            @(negedge clk);
            inj   = m_inject();
            exp_v = {(inj ? 8'h00 : din), inj, m_src, m_vec, m_bflag, m_pch, m_wi, m_busy};
            act_v = {o_op, o_inject, lat};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h want %h", i, act_v, exp_v);
            end
            tick();
        end
        sync = 0; vec_done = 0; vec_fetch = 0; ready = 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 0; sync = 0; ready = 1; nmi_n = 1; irq_n = 1; iflag = 1;
        vec_fetch = 0; vec_done = 0; din = 8'h00;
        m_reset();
        test_reset();
        test_reset_seq();
        test_passthru();
        test_nmi();
        test_irq();
        test_brk();
        test_ready();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
